// File: rtl/aes_key_schedule.sv
// ============================================================================
//  Module   : aes_key_schedule
//  Purpose  : Iterative AES-128 key expansion that emits round keys 0..10,
//             one per valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_schedule #(
    parameter int NR        = 10,
    parameter int KEY_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [KEY_WIDTH-1:0] rk_out,
    output logic [3:0]           rk_idx,
    output logic                 rk_last,
    output logic                 rk_valid,
    input  logic                 rk_ready
);

    localparam logic [3:0] c_LAST_IDX = 4'(NR);

    // Forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [127:0]     rk_q, rk_d;
    logic [3:0]       idx_q, idx_d;
    logic             last_q, last_d;

    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [31:0]      w_temp;
    logic [3:0]       w_next_idx;
    logic [127:0]     w_next_rk;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = c_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign w_rot      = {rk_q[23:0], rk_q[31:24]};
    assign w_next_idx = idx_q + 4'd1;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_subword
            assign w_sub[8*i +: 8] = sbox(w_rot[8*i +: 8]);
        end
    endgenerate

    assign w_temp = w_sub ^ {rcon(w_next_idx), 24'h000000};

    // Each new word chains off the freshly computed word to its left
    always_comb begin
        w_next_rk[127:96] = rk_q[127:96] ^ w_temp;
        w_next_rk[95:64]  = rk_q[95:64]  ^ w_next_rk[127:96];
        w_next_rk[63:32]  = rk_q[63:32]  ^ w_next_rk[95:64];
        w_next_rk[31:0]   = rk_q[31:0]   ^ w_next_rk[63:32];
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    rk_d    = key_in;
                    idx_d   = 4'd0;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (rk_ready) begin
                    if (idx_q == c_LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        rk_d  = w_next_rk;
                        idx_d = w_next_idx;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        last_d = (state_d == ST_EXPAND) && (idx_d == c_LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            idx_q   <= 4'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign rk_valid  = (state_q == ST_EXPAND);
    assign rk_out    = rk_q;
    assign rk_idx    = idx_q;
    assign rk_last   = last_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
// ============================================================================
//  Module   : tb_aes_key_schedule
//  Purpose  : Directed self-checking bench for aes_key_schedule.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_schedule;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         rk_valid;
    logic         rk_ready;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] c_KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_KEY_Z  = 128'h0;

    logic [127:0] exp_a1 [11];
    logic [127:0] exp_z  [11];

    aes_key_schedule #(.NR(10), .KEY_WIDTH(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expects round 0 visible now with rk_ready=1; returns after round 10 is accepted
    task automatic stream(input bit zero_key, input string tag);
        logic [127:0] e;
        for (int r = 0; r <= 10; r++) begin
            e = zero_key ? exp_z[r] : exp_a1[r];
            chk({tag, "_valid"}, 128'(rk_valid), 128'(1'b1));
            chk({tag, "_kready"}, 128'(key_ready), 128'(1'b0));
            chk({tag, "_idx"}, 128'(rk_idx), 128'(r));
            chk({tag, "_last"}, 128'(rk_last), 128'(r == 10));
            if (!zero_key || r == 0 || r == 1 || r == 10)
                chk({tag, "_rk"}, rk_out, e);
            @(negedge clk);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_kready"}, 128'(key_ready), 128'(1'b1));
        chk({tag, "_valid"}, 128'(rk_valid), 128'(1'b0));
        chk({tag, "_idx"}, 128'(rk_idx), 128'(0));
        chk({tag, "_last"}, 128'(rk_last), 128'(1'b0));
    endtask

    task automatic accept(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        int r;
        int cyc;
        bit rdy;
        exp_a1[0]  = c_KEY_A1;
        exp_a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int k = 0; k < 11; k++) exp_z[k] = 128'h0;
        exp_z[1]   = 128'h62636363626363636263636362636363;
        exp_z[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst_n = 1'b0; key_valid = 1'b0; rk_ready = 1'b0; key_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_idle("reset");
        chk("reset_rk", rk_out, 128'h0);

        // Test 1: FIPS-197 key, consumer always ready
        rk_ready = 1'b1;
        accept(c_KEY_A1);
        stream(1'b0, "t1");
        chk_idle("t1_end");
        chk("t1_hold", rk_out, exp_a1[10]);

        // Test 2: backpressure pattern 1,0,0 repeating
        accept(c_KEY_A1);
        r = 0;
        cyc = 0;
        while (r < 11 && cyc < 60) begin
            chk("t2_valid", 128'(rk_valid), 128'(1'b1));
            chk("t2_idx", 128'(rk_idx), 128'(r));
            chk("t2_rk", rk_out, exp_a1[r]);
            chk("t2_last", 128'(rk_last), 128'(r == 10));
            rdy = ((cyc % 3) == 0);
            rk_ready = rdy;
            @(negedge clk);
            if (rdy) r++;
            cyc++;
        end
        chk("t2_timeout", 128'(r), 128'(11));
        chk_idle("t2_end");
        rk_ready = 1'b1;

        // Test 3: all-zero key
        accept(c_KEY_Z);
        stream(1'b1, "t3");
        chk_idle("t3_end");

        // Test 4: reset in the middle of expansion, then restart
        accept(c_KEY_A1);
        repeat (5) @(negedge clk);
        chk("t4_idx5", 128'(rk_idx), 128'(5));
        chk("t4_rk5", rk_out, exp_a1[5]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("t4_rst");
        chk("t4_rst_rk", rk_out, 128'h0);
        accept(c_KEY_A1);
        stream(1'b0, "t4");
        chk_idle("t4_end");

        // Test 5: key_valid held with a different key during expansion
        key_in = c_KEY_A1;
        key_valid = 1'b1;
        @(negedge clk);
        key_in = c_KEY_Z;
        stream(1'b0, "t5a");
        chk("t5_kready", 128'(key_ready), 128'(1'b1));
        chk("t5_valid", 128'(rk_valid), 128'(1'b0));
        @(negedge clk);
        key_valid = 1'b0;
        stream(1'b1, "t5b");
        chk_idle("t5_end");

        // Test 6: back-to-back keys, 12-cycle period
        key_in = c_KEY_A1;
        key_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            chk("t6_valid", 128'(rk_valid), 128'((c % 12) != 11));
            chk("t6_idx", 128'(rk_idx), 128'(((c % 12) == 11) ? 0 : (c % 12)));
            if ((c % 12) != 11)
                chk("t6_rk", rk_out, exp_a1[c % 12]);
            @(negedge clk);
        end
        key_valid = 1'b0;
        stream(1'b0, "t6c");
        chk_idle("t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
